// File: rtl/sparam_pkg.sv
// Shared types and constants for the S-parameter sweep sequencer.
// The state enum is the reference encoding for the top-level FSM constants.
package sparam_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACQ    = 2'd2,
    EMIT   = 2'd3
  } sweep_state_e;

  localparam logic MODE_FULL = 1'b0;
  localparam logic MODE_COL  = 1'b1;

  // Number of magnitude samples folded into one S entry.
  function automatic int unsigned avg_count(input int unsigned avg_log2);
    return 32'd1 << avg_log2;
  endfunction

endpackage

// File: rtl/sparam_sweep_sequencer_if.sv
// Control, sample-stream and result-stream signals of the sweep sequencer.
// slave is the sequencer's view; master is the view of the front end / consumer.
interface sparam_sweep_sequencer_if #(
  parameter int NUM_PORTS = 4,
  parameter int SAMPLE_W  = 16
);
  localparam int IDX_W = $clog2(NUM_PORTS);

  logic                start;
  logic                mode;
  logic                abort;
  logic                busy;
  logic                done;
  logic                exc_en;
  logic [IDX_W-1:0]    exc_port;
  logic [IDX_W-1:0]    rx_port;
  logic                smp_valid;
  logic                smp_ready;
  logic [SAMPLE_W-1:0] smp_data;
  logic                res_valid;
  logic                res_ready;
  logic [IDX_W-1:0]    res_src;
  logic [IDX_W-1:0]    res_dst;
  logic [SAMPLE_W-1:0] res_data;

  modport master (
    output start, mode, abort, smp_valid, smp_data, res_ready,
    input  busy, done, exc_en, exc_port, rx_port, smp_ready,
           res_valid, res_src, res_dst, res_data
  );

  modport slave (
    input  start, mode, abort, smp_valid, smp_data, res_ready,
    output busy, done, exc_en, exc_port, rx_port, smp_ready,
           res_valid, res_src, res_dst, res_data
  );

endinterface

// File: rtl/sparam_avg_accum.sv
// Sums 2^AVG_LOG2 unsigned samples and presents the truncated mean.
// full is asserted together with the add that completes the block.
module sparam_avg_accum
  import sparam_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int AVG_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                add,
  input  logic [SAMPLE_W-1:0] data,
  output logic                full,
  output logic [SAMPLE_W-1:0] mean
);

  localparam int          ACC_W = SAMPLE_W + AVG_LOG2;
  localparam int          CNT_W = AVG_LOG2 + 1;
  localparam int unsigned N_AVG = avg_count(AVG_LOG2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_AVG - 1);

  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;

  // Accumulator and sample counter; clear wins over a coincident add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
      cnt_r <= '0;
    end else if (clear) begin
      acc_r <= '0;
      cnt_r <= '0;
    end else if (add) begin
      acc_r <= acc_r + ACC_W'(data);
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end
  end

  assign full = add && (cnt_r == CNT_LAST);
  assign mean = acc_r[ACC_W-1 -: SAMPLE_W];

endmodule

// File: rtl/sparam_sweep_sequencer.sv
// Sweep controller stepping (excitation, receive) port pairs of an N-port network,
// settling after each excitation change and emitting one averaged result per S entry.
module sparam_sweep_sequencer
  import sparam_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int SAMPLE_W      = 16,
  parameter int AVG_LOG2      = 3,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  sparam_sweep_sequencer_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_SETTLE = SETTLE;
  localparam logic [1:0] ST_ACQ    = ACQ;
  localparam logic [1:0] ST_EMIT   = EMIT;

  localparam logic [IDX_W-1:0] LAST_PORT   = IDX_W'(NUM_PORTS - 1);
  localparam logic [SET_W-1:0] LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic [SET_W-1:0]    settle_cnt_r;
  logic [SET_W-1:0]    settle_cnt_nxt_s;
  logic [IDX_W-1:0]    exc_port_r;
  logic [IDX_W-1:0]    exc_port_nxt_s;
  logic [IDX_W-1:0]    rx_port_r;
  logic [IDX_W-1:0]    rx_port_nxt_s;
  logic                mode_r;
  logic                mode_nxt_s;
  logic                done_nxt_s;
  logic                busy_r;
  logic                done_r;
  logic                exc_en_r;
  logic                smp_ready_r;
  logic                res_valid_r;
  logic                smp_fire_s;
  logic                res_fire_s;
  logic                acc_clear_s;
  logic                acc_full_s;
  logic [SAMPLE_W-1:0] acc_mean_s;

  assign smp_fire_s = bus.smp_valid && smp_ready_r;
  assign res_fire_s = res_valid_r && bus.res_ready;

  sparam_avg_accum #(
    .SAMPLE_W (SAMPLE_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_accum (
    .clk   (clk),
    .rst   (rst),
    .clear (acc_clear_s),
    .add   (smp_fire_s),
    .data  (bus.smp_data),
    .full  (acc_full_s),
    .mean  (acc_mean_s)
  );

  // Next-state logic; abort overrides every transition outside IDLE.
  always_comb begin
    state_nxt_s      = state_r;
    settle_cnt_nxt_s = settle_cnt_r;
    exc_port_nxt_s   = exc_port_r;
    rx_port_nxt_s    = rx_port_r;
    mode_nxt_s       = mode_r;
    done_nxt_s       = 1'b0;
    acc_clear_s      = 1'b0;
    if ((state_r != ST_IDLE) && bus.abort) begin
      state_nxt_s      = ST_IDLE;
      settle_cnt_nxt_s = '0;
      exc_port_nxt_s   = '0;
      rx_port_nxt_s    = '0;
      acc_clear_s      = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            state_nxt_s      = ST_SETTLE;
            mode_nxt_s       = bus.mode;
            settle_cnt_nxt_s = '0;
            exc_port_nxt_s   = '0;
            rx_port_nxt_s    = '0;
            acc_clear_s      = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_r == LAST_SETTLE) begin
            state_nxt_s      = ST_ACQ;
            settle_cnt_nxt_s = '0;
          end else begin
            settle_cnt_nxt_s = settle_cnt_r + SET_W'(1'b1);
          end
        end
        ST_ACQ: begin
          if (acc_full_s) begin
            state_nxt_s = ST_EMIT;
          end else begin
            state_nxt_s = ST_ACQ;
          end
        end
        ST_EMIT: begin
          if (res_fire_s) begin
            acc_clear_s = 1'b1;
            if (rx_port_r < LAST_PORT) begin
              rx_port_nxt_s = rx_port_r + IDX_W'(1'b1);
              state_nxt_s   = ST_ACQ;
            end else if ((mode_r == MODE_FULL) && (exc_port_r < LAST_PORT)) begin
              // New excitation port: the source must settle again.
              exc_port_nxt_s   = exc_port_r + IDX_W'(1'b1);
              rx_port_nxt_s    = '0;
              settle_cnt_nxt_s = '0;
              state_nxt_s      = ST_SETTLE;
            end else begin
              exc_port_nxt_s = '0;
              rx_port_nxt_s  = '0;
              done_nxt_s     = 1'b1;
              state_nxt_s    = ST_IDLE;
            end
          end else begin
            state_nxt_s = ST_EMIT;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          acc_clear_s = 1'b1;
        end
      endcase
    end
  end

  // State, indices and status outputs, all decoded from the next state so they are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= '0;
      exc_port_r   <= '0;
      rx_port_r    <= '0;
      mode_r       <= MODE_FULL;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      exc_en_r     <= 1'b0;
      smp_ready_r  <= 1'b0;
      res_valid_r  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      settle_cnt_r <= settle_cnt_nxt_s;
      exc_port_r   <= exc_port_nxt_s;
      rx_port_r    <= rx_port_nxt_s;
      mode_r       <= mode_nxt_s;
      busy_r       <= (state_nxt_s != ST_IDLE);
      done_r       <= done_nxt_s;
      exc_en_r     <= (state_nxt_s != ST_IDLE);
      smp_ready_r  <= (state_nxt_s == ST_ACQ);
      res_valid_r  <= (state_nxt_s == ST_EMIT);
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.exc_en    = exc_en_r;
  assign bus.exc_port  = exc_port_r;
  assign bus.rx_port   = rx_port_r;
  assign bus.smp_ready = smp_ready_r;
  assign bus.res_valid = res_valid_r;
  assign bus.res_src   = exc_port_r;
  assign bus.res_dst   = rx_port_r;
  assign bus.res_data  = acc_mean_s;

endmodule

// File: tb/tb_sparam_sweep_sequencer.sv
// Randomized bench for sparam_sweep_sequencer: a sample-stream model predicts every
// averaged result, its (src,dst) order, done timing, settle length and sweep duration.
module tb_sparam_sweep_sequencer;
  import sparam_pkg::*;

  localparam int NP   = 4;
  localparam int SW   = 16;
  localparam int AL   = 3;
  localparam int SC   = 8;
  localparam int NAVG = 8;
  localparam int FULL_CYC = NP * SC + NP * NP * (NAVG + 1);
  localparam int COL_CYC  = SC + NP * (NAVG + 1);

  logic clk = 1'b0;
  logic rst;
  int   check_cnt = 0;
  int   err_cnt   = 0;

  always #5 clk = ~clk;

  sparam_sweep_sequencer_if #(.NUM_PORTS(NP), .SAMPLE_W(SW)) bus ();

  sparam_sweep_sequencer #(
    .NUM_PORTS(NP), .SAMPLE_W(SW), .AVG_LOG2(AL), .SETTLE_CYCLES(SC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({bus.busy, bus.done, bus.exc_en, bus.smp_ready, bus.res_valid,
                bus.exc_port, bus.rx_port, bus.res_src, bus.res_dst, bus.res_data});
  endfunction

  // pat: 0 const 100, 1 ramp 0..7 per pair, 2 all 0xFFFF, else random
  task automatic run_sweep(input logic m, input int pat, input bit gaps, input int stall_res,
                           input int abort_at, input bit spam, input int exp_cyc);
    int nres, sidx, ridx, cyc, done_cnt, done_cyc, last_acc, idle_gap, exc_max, settle_n, stall_n;
    bit saw_ready;
    logic [31:0] held, payload;
    int unsigned samp[$];
    int unsigned exp_val[$];
    nres = (m == MODE_COL) ? NP : NP * NP;
    sidx = 0; ridx = 0; cyc = 0; done_cnt = 0; done_cyc = -1; last_acc = -10;
    idle_gap = 0; exc_max = 0; settle_n = 0; stall_n = 0; saw_ready = 1'b0; held = '0;
    for (int i = 0; i < nres * NAVG; i++) begin
      case (pat)
        0:       samp.push_back(32'd100);
        1:       samp.push_back(32'(i % NAVG));
        2:       samp.push_back(32'hFFFF);
        default: samp.push_back($urandom_range(0, 65535));
      endcase
    end
    for (int k = 0; k < nres; k++) begin
      int unsigned sum;
      sum = 0;
      for (int j = 0; j < NAVG; j++) sum += samp[k * NAVG + j];
      exp_val.push_back(sum / NAVG);
    end

    @(negedge clk);
    bus.mode  = m;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = ~m;
    while (cyc < 4000) begin
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
        check_val("done_idle", 32'({bus.busy, bus.exc_en, bus.smp_ready, bus.res_valid}), 32'd0);
      end else if (!bus.busy && done_cnt == 0) begin
        idle_gap++;
      end
      if (int'(bus.exc_port) > exc_max) exc_max = int'(bus.exc_port);
      if (!saw_ready) begin
        if (bus.smp_ready) saw_ready = 1'b1;
        else if (bus.exc_en) settle_n++;
      end
      if (done_cnt > 0 && cyc - done_cyc >= 3) break;

      if (abort_at > 0 && sidx == abort_at) begin
        bus.smp_valid = 1'b0;
        bus.res_ready = 1'b1;
        bus.abort     = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_val("abort_idle",
                  32'({bus.busy, bus.exc_en, bus.smp_ready, bus.res_valid, bus.done}), 32'd0);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check_val("abort_no_done", 32'({bus.done, bus.busy}), 32'd0);
        end
        check_val("abort_results", 32'(ridx), 32'(abort_at / NAVG));
        return;
      end

      bus.smp_valid = (sidx < samp.size()) && (!gaps || (cyc % 3 == 0));
      bus.smp_data  = bus.smp_valid ? 16'(samp[sidx]) : 16'($urandom);
      bus.start     = spam && (done_cnt == 0) && (cyc % 17 == 5);
      bus.res_ready = 1'b1;
      payload = 32'({bus.res_src, bus.res_dst, bus.res_data});
      if (ridx == stall_res && stall_n < 5 && (bus.res_valid || stall_n > 0)) begin
        if (stall_n == 0) begin
          held = payload;
        end else begin
          check_val("stall_valid", 32'(bus.res_valid), 32'd1);
          check_val("stall_payload", payload, held);
          check_val("stall_smp_ready", 32'(bus.smp_ready), 32'd0);
        end
        bus.res_ready = 1'b0;
        stall_n++;
      end

      if (bus.res_valid && bus.res_ready) begin
        if (ridx < nres) begin
          check_val("res_src", 32'(bus.res_src), 32'((m == MODE_COL) ? 0 : ridx / NP));
          check_val("res_dst", 32'(bus.res_dst), 32'(ridx % NP));
          check_val("res_data", 32'(bus.res_data), exp_val[ridx]);
        end else begin
          check_val("extra_result", 32'(ridx), 32'(nres));
        end
        ridx++;
        last_acc = cyc;
      end
      if (bus.smp_valid && bus.smp_ready) sidx++;
      cyc++;
      @(negedge clk);
    end

    if (cyc >= 4000) check_val("timeout", 32'd0, 32'd1);
    check_val("res_count", 32'(ridx), 32'(nres));
    check_val("done_count", 32'(done_cnt), 32'd1);
    check_val("done_after_accept", 32'(done_cyc - last_acc), 32'd1);
    check_val("busy_held", 32'(idle_gap), 32'd0);
    check_val("settle_len", 32'(settle_n), 32'(SC));
    if (m == MODE_COL) check_val("col_exc_port", 32'(exc_max), 32'd0);
    if (exp_cyc > 0) check_val("sweep_cycles", 32'(done_cyc), 32'(exp_cyc));
    bus.start     = 1'b0;
    bus.smp_valid = 1'b0;
    bus.mode      = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.mode      = 1'b0;
    bus.abort     = 1'b0;
    bus.smp_valid = 1'b0;
    bus.smp_data  = 16'h0;
    bus.res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs", all_outputs(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("idle_after_reset", all_outputs(), 32'd0);

    run_sweep(MODE_FULL, 0, 1'b0, -1, 0, 1'b0, FULL_CYC);
    run_sweep(MODE_FULL, 1, 1'b0, -1, 0, 1'b0, FULL_CYC);
    run_sweep(MODE_FULL, 2, 1'b0, -1, 0, 1'b0, FULL_CYC);
    run_sweep(MODE_COL,  3, 1'b0, -1, 0, 1'b0, COL_CYC);
    run_sweep(MODE_FULL, 3, 1'b0,  5, 0, 1'b0, -1);
    // abort after 3 samples of pair (1,2), then a fresh sweep from (0,0)
    run_sweep(MODE_FULL, 3, 1'b0, -1, 6 * NAVG + 3, 1'b0, -1);
    run_sweep(MODE_FULL, 3, 1'b0, -1, 0, 1'b0, FULL_CYC);
    run_sweep(MODE_FULL, 3, 1'b1, -1, 0, 1'b1, -1);

    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_val("abort_beats_start", 32'({bus.busy, bus.exc_en}), 32'd0);

    bus.mode  = MODE_FULL;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.smp_valid = 1'b1;
    bus.smp_data  = 16'd7;
    bus.res_ready = 1'b1;
    repeat (25) @(negedge clk);
    check_val("busy_mid_sweep", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check_val("async_reset_outputs", all_outputs(), 32'd0);
    @(negedge clk);
    rst           = 1'b0;
    bus.smp_valid = 1'b0;
    @(negedge clk);
    check_val("idle_after_mid_reset", all_outputs(), 32'd0);
    run_sweep(MODE_COL, 3, 1'b0, -1, 0, 1'b0, COL_CYC);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", check_cnt, err_cnt);
    $fatal(1);
  end

endmodule
